tipi_link_seq: RTL and testbench

TIPI_LINK_SEQ -- requirements
Module: tipi_link_seq

---
 rtl/tipi_link_seq_if.sv | 12 +
 rtl/tipi_link_seq.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_tipi_link_seq.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tipi_link_seq_if.sv
// TIPI link register bus: Pi-side control/data bytes in, TI-side bytes and write strobes out.
interface tipi_link_seq_if;
    logic [7:0] tc;
    logic [7:0] td;
    logic [7:0] rc;
    logic [7:0] rd;
    logic       rc_we;
    logic       rd_we;

    modport master (input tc, td, output rc, rd, rc_we, rd_we);
    modport slave  (output tc, td, input rc, rd, rc_we, rd_we);
endinterface

// File: rtl/tipi_link_seq.sv
// TIPI link message sequencer: byte-wise toggle handshake over the rc/rd/tc/td registers.
// Optional handshake watchdog enabled by defining TIPI_LINK_SEQ_TIMEOUT_EN.
module tipi_link_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    tipi_link_seq_if.master lnk,
    input  logic        link_reset_evt,
    input  logic        tx_start,
    input  logic [15:0] tx_len,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic        rx_start,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [15:0] rx_len,
    output logic        synced,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [2:0] {
        S_SYNC, S_IDLE, S_TX_BYTE, S_TX_ACK, S_RX_REQ, S_RX_ACK, S_RX_OUT
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hF1;
    localparam logic [7:0] TX_CMD    = 8'h02;
    localparam logic [7:0] RX_CMD    = 8'h06;

    state_t      state_q, state_d;
    logic [7:0]  rc_q, rc_d, rd_q, rd_d;
    logic        rc_we_q, rc_we_d, rd_we_q, rd_we_d;
    logic        t_q, t_d;
    logic        ph_q, ph_d;
    logic [1:0]  hdr_q, hdr_d;
    logic [15:0] len_q, len_d, rem_q, rem_d;
    logic [15:0] rx_len_q, rx_len_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        sync_wr_q, sync_wr_d;
    logic        synced_q, synced_d;
    logic        done_q, done_d, err_q, err_d;

    logic        abort_w, ack_w, busy_w, tmo_hit;
    logic [15:0] rx_len_new;

    assign abort_w    = link_reset_evt | ~enable;
    assign ack_w      = (lnk.tc == rc_q);
    assign busy_w     = (state_q != S_IDLE) && (state_q != S_SYNC);
    assign rx_len_new = {rx_len_q[15:8], lnk.td};

`ifdef TIPI_LINK_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_cnt_w;

    assign tmo_cnt_w = (state_q == S_TX_ACK) || (state_q == S_RX_ACK) || (state_q == S_SYNC);
    assign tmo_hit   = tmo_cnt_w && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    // Counter restarts on every state change so each handshake gets its own budget.
    assign tmo_d     = (abort_w || !tmo_cnt_w || (state_d != state_q) || tmo_hit) ?
                       '0 : tmo_q + TMO_W'(1);

    always_ff @(posedge clk) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    // Watchdog compiled out; the limit folds away.
    assign tmo_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_SYNC;
            rc_q      <= 8'h00;
            rd_q      <= 8'h00;
            rc_we_q   <= 1'b0;
            rd_we_q   <= 1'b0;
            t_q       <= 1'b0;
            ph_q      <= 1'b0;
            hdr_q     <= 2'd0;
            rx_len_q  <= 16'h0000;
            sync_wr_q <= 1'b0;
            synced_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rc_q      <= rc_d;
            rd_q      <= rd_d;
            rc_we_q   <= rc_we_d;
            rd_we_q   <= rd_we_d;
            t_q       <= t_d;
            ph_q      <= ph_d;
            hdr_q     <= hdr_d;
            rx_len_q  <= rx_len_d;
            sync_wr_q <= sync_wr_d;
            synced_q  <= synced_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
        len_q     <= len_d;
        rem_q     <= rem_d;
        rx_data_q <= rx_data_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort_w) begin
            state_d = S_SYNC;
        end else begin
            case (state_q)
                S_SYNC:    if (sync_wr_q && lnk.tc == SYNC_BYTE) state_d = S_IDLE;
                S_IDLE:    if (tx_start) state_d = S_TX_BYTE;
                           else if (rx_start) state_d = S_RX_REQ;
                S_TX_BYTE: if (ph_q) state_d = S_TX_ACK;
                S_TX_ACK: begin
                    if (ack_w) begin
                        case (hdr_q)
                            2'd0:    state_d = S_TX_BYTE;
                            2'd1:    state_d = (len_q == 16'd0) ? S_IDLE : S_TX_BYTE;
                            default: state_d = (rem_q == 16'd1) ? S_IDLE : S_TX_BYTE;
                        endcase
                    end else if (tmo_hit) begin
                        state_d = S_SYNC;
                    end
                end
                S_RX_REQ:  state_d = S_RX_ACK;
                S_RX_ACK: begin
                    if (ack_w) begin
                        case (hdr_q)
                            2'd0:    state_d = S_RX_REQ;
                            2'd1:    state_d = (rx_len_new == 16'd0) ? S_IDLE : S_RX_REQ;
                            default: state_d = S_RX_OUT;
                        endcase
                    end else if (tmo_hit) begin
                        state_d = S_SYNC;
                    end
                end
                S_RX_OUT:  if (rx_ready) state_d = (rem_q == 16'd1) ? S_IDLE : S_RX_REQ;
                default:   state_d = S_SYNC;
            endcase
        end
    end

    always_comb begin
        rc_d      = rc_q;
        rd_d      = rd_q;
        rc_we_d   = 1'b0;
        rd_we_d   = 1'b0;
        t_d       = t_q;
        ph_d      = ph_q;
        hdr_d     = hdr_q;
        len_d     = len_q;
        rem_d     = rem_q;
        rx_len_d  = rx_len_q;
        rx_data_d = rx_data_q;
        sync_wr_d = sync_wr_q;
        synced_d  = synced_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (abort_w) begin
            err_d     = busy_w;
            synced_d  = 1'b0;
            sync_wr_d = 1'b0;
            ph_d      = 1'b0;
        end else begin
            case (state_q)
                S_SYNC: begin
                    if (!sync_wr_q) begin
                        rc_d      = SYNC_BYTE;
                        rc_we_d   = 1'b1;
                        sync_wr_d = 1'b1;
                    end else if (lnk.tc == SYNC_BYTE) begin
                        synced_d = 1'b1;
                        t_d      = 1'b0;
                    end else if (tmo_hit) begin
                        err_d     = 1'b1;
                        sync_wr_d = 1'b0;
                    end
                end
                S_IDLE: begin
                    hdr_d = 2'd0;
                    ph_d  = 1'b0;
                    if (tx_start) len_d = tx_len;
                end
                S_TX_BYTE: begin
                    // Data byte goes out one cycle ahead of its rc strobe.
                    if (!ph_q) begin
                        if (hdr_q != 2'd2 || tx_valid) begin
                            case (hdr_q)
                                2'd0:    rd_d = len_q[15:8];
                                2'd1:    rd_d = len_q[7:0];
                                default: rd_d = tx_data;
                            endcase
                            rd_we_d = 1'b1;
                            ph_d    = 1'b1;
                        end
                    end else begin
                        rc_d    = TX_CMD | {7'd0, t_q};
                        rc_we_d = 1'b1;
                        ph_d    = 1'b0;
                    end
                end
                S_TX_ACK: begin
                    if (ack_w) begin
                        t_d = ~t_q;
                        case (hdr_q)
                            2'd0: hdr_d = 2'd1;
                            2'd1: begin
                                if (len_q == 16'd0) begin
                                    done_d = 1'b1;
                                end else begin
                                    hdr_d = 2'd2;
                                    rem_d = len_q;
                                end
                            end
                            default: begin
                                rem_d = rem_q - 16'd1;
                                if (rem_q == 16'd1) done_d = 1'b1;
                            end
                        endcase
                    end else if (tmo_hit) begin
                        err_d     = 1'b1;
                        sync_wr_d = 1'b0;
                        synced_d  = 1'b0;
                    end
                end
                S_RX_REQ: begin
                    rc_d    = RX_CMD | {7'd0, t_q};
                    rc_we_d = 1'b1;
                end
                S_RX_ACK: begin
                    if (ack_w) begin
                        t_d = ~t_q;
                        case (hdr_q)
                            2'd0: begin
                                rx_len_d[15:8] = lnk.td;
                                hdr_d          = 2'd1;
                            end
                            2'd1: begin
                                rx_len_d[7:0] = lnk.td;
                                if (rx_len_new == 16'd0) begin
                                    done_d = 1'b1;
                                end else begin
                                    hdr_d = 2'd2;
                                    rem_d = rx_len_new;
                                end
                            end
                            default: rx_data_d = lnk.td;
                        endcase
                    end else if (tmo_hit) begin
                        err_d     = 1'b1;
                        sync_wr_d = 1'b0;
                        synced_d  = 1'b0;
                    end
                end
                S_RX_OUT: begin
                    if (rx_ready) begin
                        rem_d = rem_q - 16'd1;
                        if (rem_q == 16'd1) done_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lnk.rc    = rc_q;
    assign lnk.rd    = rd_q;
    assign lnk.rc_we = rc_we_q;
    assign lnk.rd_we = rd_we_q;
    assign tx_ready  = !abort_w && (state_q == S_TX_BYTE) && !ph_q && (hdr_q == 2'd2) && tx_valid;
    assign rx_valid  = (state_q == S_RX_OUT);
    assign rx_data   = rx_data_q;
    assign rx_len    = rx_len_q;
    assign synced    = synced_q;
    assign busy      = busy_w;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_tipi_link_seq.sv
// Scoreboard bench for tipi_link_seq: a Pi responder echoes rc after a delay, a monitor checks strobes.
module tb_tipi_link_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        link_reset_evt = 1'b0;
    logic        tx_start = 1'b0;
    logic [15:0] tx_len = 16'h0000;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        rx_start = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] rx_len;
    logic        synced, busy, done, err;

    tipi_link_seq_if lnk ();

    tipi_link_seq #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .lnk(lnk),
        .link_reset_evt(link_reset_evt),
        .tx_start(tx_start), .tx_len(tx_len), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_start(rx_start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_len(rx_len),
        .synced(synced), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_rd[$];
    logic [7:0] exp_rc[$];
    logic [7:0] exp_rx[$];
    int         exp_ev[$];     // 1 = done pulse, 2 = err pulse
    logic [7:0] tx_fifo[$];
    logic [7:0] td_fifo[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    bit         echo_en = 1'b1;
    int         echo_dly = 5;
    int         rx_hold = 4;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Pi side: echo every rc write back on tc after echo_dly cycles, presenting td with RX requests.
    initial begin
        int         cnt;
        logic [7:0] pv;
        cnt = 0; pv = 8'h00; lnk.tc = 8'h00; lnk.td = 8'h00;
        forever begin
            @(negedge clk);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    if (pv[7:1] == 7'h03 && td_fifo.size() > 0) lnk.td = td_fifo.pop_front();
                    lnk.tc = pv;
                end
            end
            if (lnk.rc_we && echo_en) begin
                pv  = lnk.rc;
                cnt = echo_dly;
            end
        end
    end

    initial begin
        logic c;
        tx_valid = 1'b0; tx_data = 8'h00; c = 1'b0;
        forever begin
            @(negedge clk);
            c = tx_ready;
            @(posedge clk);
            #1;
            if (c && tx_fifo.size() > 0) tx_fifo.delete(0);
            tx_valid = (tx_fifo.size() > 0);
            tx_data  = tx_valid ? tx_fifo[0] : 8'h00;
        end
    end

    initial begin
        int cnt;
        cnt = 0; rx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rx_valid && !rx_ready) begin
                cnt++;
                if (cnt >= rx_hold) rx_ready = 1'b1;
            end else begin
                rx_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        logic       pv;
        logic [7:0] pd;
        pv = 1'b0; pd = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (lnk.rd_we || lnk.rc_we) chk("strobe overlap", {31'd0, lnk.rd_we & lnk.rc_we}, 0);
                if (lnk.rd_we) begin
                    if (exp_rd.size() == 0) chk("rd write expected", exp_rd.size(), 1);
                    else chk("rd byte", lnk.rd, exp_rd.pop_front());
                end
                if (lnk.rc_we) begin
                    if (exp_rc.size() == 0) chk("rc write expected", exp_rc.size(), 1);
                    else chk("rc byte", lnk.rc, exp_rc.pop_front());
                end
                if (rx_valid && pv) chk("rx_data hold", rx_data, pd);
                if (rx_valid && rx_ready) begin
                    if (exp_rx.size() == 0) chk("rx transfer expected", exp_rx.size(), 1);
                    else chk("rx byte", rx_data, exp_rx.pop_front());
                end
                if (done) begin
                    if (exp_ev.size() == 0) chk("done expected", exp_ev.size(), 1);
                    else chk("event done", 1, exp_ev.pop_front());
                end
                if (err) begin
                    if (exp_ev.size() == 0) chk("err expected", exp_ev.size(), 1);
                    else chk("event err", 2, exp_ev.pop_front());
                end
            end
            pv = rx_valid && !rx_ready;
            pd = rx_data;
        end
    end

    task automatic wait_drain(input string nm, input int maxc, input bit need_sync);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (exp_rd.size() == 0 && exp_rc.size() == 0 && exp_rx.size() == 0 &&
                exp_ev.size() == 0 && !busy && (!need_sync || synced)) begin
                ok = 1'b1;
                break;
            end
        end
        chk({"drain ", nm}, {31'd0, ok}, 1);
        if (!ok) begin
            exp_rd.delete(); exp_rc.delete(); exp_rx.delete(); exp_ev.delete();
        end
    endtask

    task automatic start(input bit do_tx, input bit do_rx, input logic [15:0] len);
        @(posedge clk);
        #1;
        tx_len = len; tx_start = do_tx; rx_start = do_rx;
        @(posedge clk);
        #1;
        tx_start = 1'b0; rx_start = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset rc", lnk.rc, 8'h00);
        chk("reset rd", lnk.rd, 8'h00);
        chk("reset strobes", {30'd0, lnk.rc_we, lnk.rd_we}, 0);
        chk("reset busy/synced", {30'd0, busy, synced}, 0);
        chk("reset done/err", {30'd0, done, err}, 0);
        chk("reset rx_valid/tx_ready", {30'd0, rx_valid, tx_ready}, 0);
        chk("reset rx_len", rx_len, 16'h0000);

        exp_rc.push_back(8'hF1);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_drain("sync", 60, 1'b1);
        chk("synced", synced, 1);
        echo_dly = 3;

        // TX of two payload bytes
        tx_fifo = '{8'hAA, 8'h55};
        exp_rd  = '{8'h00, 8'h02, 8'hAA, 8'h55};
        exp_rc  = '{8'h02, 8'h03, 8'h02, 8'h03};
        exp_ev.push_back(1);
        start(1'b1, 1'b0, 16'h0002);
        @(negedge clk);
        chk("busy during tx", busy, 1);
        wait_drain("tx2", 200, 1'b0);

        // RX of one payload byte, held four cycles
        td_fifo = '{8'h00, 8'h01, 8'h7E};
        exp_rc  = '{8'h06, 8'h07, 8'h06};
        exp_rx.push_back(8'h7E);
        exp_ev.push_back(1);
        start(1'b0, 1'b1, 16'h0000);
        wait_drain("rx1", 200, 1'b0);
        chk("rx_len", rx_len, 16'h0001);

        // simultaneous starts: TX only
        tx_fifo = '{8'h3C};
        exp_rd  = '{8'h00, 8'h01, 8'h3C};
        exp_rc  = '{8'h03, 8'h02, 8'h03};
        exp_ev.push_back(1);
        start(1'b1, 1'b1, 16'h0001);
        wait_drain("tx+rx", 200, 1'b0);
        repeat (10) @(negedge clk);
        chk("rx dropped busy", busy, 0);
        chk("rx dropped rc queue", exp_rc.size(), 0);

        // zero-length TX and RX
        exp_rd = '{8'h00, 8'h00};
        exp_rc = '{8'h02, 8'h03};
        exp_ev.push_back(1);
        start(1'b1, 1'b0, 16'h0000);
        wait_drain("tx0", 200, 1'b0);
        td_fifo = '{8'h00, 8'h00};
        exp_rc  = '{8'h06, 8'h07};
        exp_ev.push_back(1);
        start(1'b0, 1'b1, 16'h0000);
        wait_drain("rx0", 200, 1'b0);
        chk("rx_len zero", rx_len, 16'h0000);

        // link reset during the second payload byte
        tx_fifo = '{8'h11, 8'h22, 8'h33};
        exp_rd  = '{8'h00, 8'h03, 8'h11, 8'h22};
        exp_rc  = '{8'h02, 8'h03, 8'h02, 8'hF1};
        exp_ev.push_back(2);
        start(1'b1, 1'b0, 16'h0003);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (lnk.rd_we && lnk.rd == 8'h22) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort trigger seen", {31'd0, found}, 1);
        link_reset_evt = 1'b1;
        @(posedge clk);
        #1 link_reset_evt = 1'b0;
        tx_fifo.delete();
        wait_drain("abort", 200, 1'b1);
        chk("resynced", synced, 1);

        // Pi never echoes
        echo_en = 1'b0;
        tx_fifo = '{8'h5A};
        exp_rd  = '{8'h00};
        exp_rc  = '{8'h02};
`ifdef TIPI_LINK_SEQ_TIMEOUT_EN
        exp_rc.push_back(8'hF1);
        exp_ev.push_back(2);
        start(1'b1, 1'b0, 16'h0001);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (err) begin
                found = 1'b1;
                break;
            end
        end
        echo_en = 1'b1;
        chk("timeout err seen", {31'd0, found}, 1);
        tx_fifo.delete();
        wait_drain("timeout", 200, 1'b1);
`else
        start(1'b1, 1'b0, 16'h0001);
        repeat (40) @(negedge clk);
        chk("stalled busy", busy, 1);
        chk("stalled rc queue", exp_rc.size(), 0);
        chk("stalled no err", err, 0);
        exp_ev.push_back(2);
        exp_rc.push_back(8'hF1);
        echo_en = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 enable = 1'b1;
        tx_fifo.delete();
        wait_drain("disable", 200, 1'b1);
`endif
        chk("final synced", synced, 1);
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end
endmodule
